// File: rtl/synth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synth_pkg: wave codes, FSM states, LFSR constants, saturation helper |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package synth_pkg;

  localparam logic [1:0] WAVE_SAW    = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_OFF    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Clamp to the range of a signed value of the given width.
  function automatic int saturate(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/synth_wave_shape.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synth_wave_shape: phase MSBs + wave code -> signed waveform sample   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module synth_wave_shape
  import synth_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic        [OUT_W-1:0] i_phase,
  input  logic        [1:0]       i_wave,
  output logic signed [OUT_W-1:0] o_shape
);

  logic             w_msb;
  logic [OUT_W-2:0] w_u;

  always_comb begin
    w_msb   = i_phase[OUT_W-1];
    // Fold the second half of the period back down for the triangle.
    w_u     = w_msb ? ~i_phase[OUT_W-2:0] : i_phase[OUT_W-2:0];
    o_shape = '0;
    case (i_wave)
      WAVE_SAW:    o_shape = {~w_msb, i_phase[OUT_W-2:0]};
      WAVE_SQUARE: o_shape = w_msb ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      WAVE_TRI:    o_shape = {~w_u[OUT_W-2], w_u[OUT_W-3:0], 1'b0};
      default:     o_shape = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/synth_voice_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synth_voice_mixer: N-voice time-multiplexed oscillator + mixer.      |
// | Define SYNTH_NOISE_EN to turn wave code 3 into LFSR noise.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module synth_voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 16,
  parameter int SAMPLE_DIV = 10
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] i_cfg_voice,
  input  logic [ACC_W-1:0]              i_cfg_fcw,
  input  logic [1:0]                    i_cfg_wave,
  input  logic [7:0]                    i_cfg_level,
  output logic [OUT_W-1:0]              o_sample,
  output logic                          o_valid,
  output logic                          o_busy
);

  localparam int c_VW     = $clog2(NUM_VOICES);
  localparam int c_SUM_W  = OUT_W + c_VW + 1;
  localparam int c_PROD_W = OUT_W + 9;
  localparam int c_CNT_W  = $clog2(SAMPLE_DIV);
  localparam logic [c_VW-1:0]    c_LAST_V   = c_VW'(NUM_VOICES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SAMPLE_DIV - 1);

  logic [ACC_W-1:0] r_phase [NUM_VOICES];
  logic [ACC_W-1:0] r_fcw   [NUM_VOICES];
  logic [1:0]       r_wave  [NUM_VOICES];
  logic [7:0]       r_level [NUM_VOICES];

  logic [c_CNT_W-1:0]        r_cnt;
  state_t                    r_state;
  state_t                    w_state_next;
  logic [c_VW-1:0]           r_v;
  logic signed [c_SUM_W-1:0] r_sum;
  logic [OUT_W-1:0]          r_sample;
  logic                      r_valid;

  logic                       w_tick;
  logic [ACC_W-1:0]           w_phase_cur;
  logic [ACC_W-1:0]           w_fcw_cur;
  logic [1:0]                 w_wave_cur;
  logic [7:0]                 w_level_cur;
  logic signed [OUT_W-1:0]    w_shape;
  logic signed [OUT_W-1:0]    w_src;
  logic signed [c_PROD_W-1:0] w_prod;

  assign w_tick      = (r_cnt == '0) && (r_state == IDLE);
  assign w_phase_cur = r_phase[r_v];
  assign w_fcw_cur   = r_fcw[r_v];
  assign w_wave_cur  = r_wave[r_v];
  assign w_level_cur = r_level[r_v];

  synth_wave_shape #(
    .OUT_W(OUT_W)
  ) u_shape (
    .i_phase(w_phase_cur[ACC_W-1 -: OUT_W]),
    .i_wave (w_wave_cur),
    .o_shape(w_shape)
  );

`ifdef SYNTH_NOISE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == OUT) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign w_src = (w_wave_cur == WAVE_OFF) ? OUT_W'($signed(r_lfsr)) : w_shape;
`else
  assign w_src = w_shape;
`endif

  // Signed shape times unsigned level; the zero-extended level keeps the product signed.
  assign w_prod = c_PROD_W'(w_src) * c_PROD_W'($signed({1'b0, w_level_cur}));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_state_next = ACCUM;
      ACCUM:   if (r_v == c_LAST_V) w_state_next = OUT;
      OUT:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i] <= '0;
        r_fcw[i]   <= '0;
        r_wave[i]  <= WAVE_OFF;
        r_level[i] <= '0;
      end
      r_cnt    <= '0;
      r_v      <= '0;
      r_sum    <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_cnt   <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_valid <= (r_state == OUT);
      // Config lands at the edge, so a voice being swept this cycle still sees its old values.
      if (i_cfg_we) begin
        r_fcw[i_cfg_voice]   <= i_cfg_fcw;
        r_wave[i_cfg_voice]  <= i_cfg_wave;
        r_level[i_cfg_voice] <= i_cfg_level;
      end
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_v   <= '0;
            r_sum <= '0;
          end
        end
        ACCUM: begin
          r_phase[r_v] <= w_phase_cur + w_fcw_cur;
          r_sum        <= r_sum + c_SUM_W'(w_prod >>> 8);
          r_v          <= r_v + 1'b1;
        end
        OUT: begin
          r_sample <= OUT_W'(saturate(int'(r_sum), OUT_W));
        end
        default: ;
      endcase
    end
  end

  assign o_sample = r_sample;
  assign o_valid  = r_valid;
  assign o_busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_synth_voice_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_synth_voice_mixer: vector table, corner sequences, random config  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_synth_voice_mixer;

  localparam int N   = 4;
  localparam int DIV = 10;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cfg_we = 1'b0;
  logic [1:0]  i_cfg_voice = '0;
  logic [23:0] i_cfg_fcw = '0;
  logic [1:0]  i_cfg_wave = '0;
  logic [7:0]  i_cfg_level = '0;
  logic [15:0] o_sample;
  logic        o_valid;
  logic        o_busy;

  synth_voice_mixer #(
    .NUM_VOICES(N),
    .ACC_W     (24),
    .OUT_W     (16),
    .SAMPLE_DIV(DIV)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_voice(i_cfg_voice),
    .i_cfg_fcw  (i_cfg_fcw),
    .i_cfg_wave (i_cfg_wave),
    .i_cfg_level(i_cfg_level),
    .o_sample   (o_sample),
    .o_valid    (o_valid),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycle index since reset release plus per-voice state.
  int c;
  int m_phase [N];
  int m_fcw   [N];
  int m_wave  [N];
  int m_level [N];
  int m_acc;
  int m_sample;
  logic [15:0] m_lfsr;
  int got [$];

  typedef struct {
    int all_voices;
    int wave;
    int fcw;
    int level;
    int exp1;
    int exp2;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, c);
    end
  endtask

  function automatic int shape_of(input int p, input int w);
    case (w)
      0: return p - 32768;
      1: return (p < 32768) ? 32767 : -32768;
      2: return 2 * ((p < 32768) ? p : 65535 - p) - 32768;
`ifdef SYNTH_NOISE_EN
      default: return int'($signed(m_lfsr));
`else
      default: return 0;
`endif
    endcase
  endfunction

  function automatic int scale(input int s, input int lvl);
    int x;
    x = s * lvl;
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  function automatic int clamp(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0;
      m_fcw[i]   = 0;
      m_wave[i]  = 3;
      m_level[i] = 0;
    end
    m_acc    = 0;
    m_sample = 0;
    m_lfsr   = 16'hACE1;
    c        = 0;
    got.delete();
  endtask

  // Called at the falling edge of cycle c: check, advance model, drive this cycle's write.
  task automatic step(input int we, input int voice, input int fcw, input int wave, input int level);
    int k;
    int v;
    k = c % DIV;
    chk("valid", int'(o_valid), (k == N + 2) ? 1 : 0);
    chk("busy", int'(o_busy), (k >= 1 && k <= N + 1) ? 1 : 0);
    chk("sample", int'($signed(o_sample)), m_sample);
    if (o_valid) got.push_back(int'($signed(o_sample)));
    if (k == 0) m_acc = 0;
    if (k >= 1 && k <= N) begin
      v = k - 1;
      m_acc += scale(shape_of(m_phase[v] / 256, m_wave[v]), m_level[v]);
      m_phase[v] = (m_phase[v] + m_fcw[v]) % (1 << 24);
    end
    if (k == N + 1) begin
      m_sample = clamp(m_acc);
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    i_cfg_we    = (we != 0);
    i_cfg_voice = 2'(voice);
    i_cfg_fcw   = 24'(fcw);
    i_cfg_wave  = 2'(wave);
    i_cfg_level = 8'(level);
    if (we != 0) begin
      m_fcw[voice]   = fcw;
      m_wave[voice]  = wave;
      m_level[voice] = level;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    c++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    i_rst    = 1'b1;
    i_cfg_we = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_samples(input int n);
    int guard;
    guard = 0;
    while (got.size() < n && guard < 40) begin
      idle();
      guard++;
    end
    chk("sample_count", got.size(), n);
  endtask

  initial begin
    vecs[0] = '{0, 0, 32'h100000, 255, -32640, -28560};
    vecs[1] = '{1, 1, 32'h800000, 255, 32767, -32768};
    vecs[2] = '{0, 0, 32'hFFFFFF, 255, -32640, 32639};
    vecs[3] = '{1, 3, 32'h123456, 255, 0, 0};
    vecs[4] = '{0, 2, 32'h400000, 128, -16384, 0};
    vecs[5] = '{1, 0, 32'h000000, 255, -32768, -32768};

    @(negedge i_clk);
    do_reset();

    // Idle after reset: pulses every DIV clocks, first at cycle 6, sample stays 0.
    wait_samples(3);
    if (got.size() >= 3) chk("idle_zero", got[0] | got[1] | got[2], 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int v = 0; v < N; v++) begin
        if (vecs[i].all_voices != 0 || v == 0)
          step(1, v, vecs[i].fcw, vecs[i].wave, vecs[i].level);
        else
          idle();
      end
      wait_samples(2);
      if (got.size() >= 2) begin
        chk($sformatf("vec%0d_s1", i), got[0], vecs[i].exp1);
        chk($sformatf("vec%0d_s2", i), got[1], vecs[i].exp2);
      end
    end

    // Write to voice 2 in the very cycle it is being swept.
    do_reset();
    step(1, 0, 32'h100000, 0, 255);
    step(1, 2, 0, 1, 0);
    while (c < 13) idle();
    step(1, 2, 0, 1, 255);
    wait_samples(3);
    if (got.size() >= 3) begin
      chk("collide_s1", got[0], -32640);
      chk("collide_s2", got[1], -28560);
      chk("collide_s3", got[2], 8159);
    end

    // Reset asserted mid-ACCUM abandons the sweep.
    do_reset();
    step(1, 0, 32'h100000, 0, 255);
    while (c < 12) idle();
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_sample", int'($signed(o_sample)), 0);
    i_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) idle();
    chk("rst_resume_pulses", got.size(), 2);

    // Random configuration traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 24'hFFFFFF)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      else
        idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
